// File: rtl/dmem_pkg.sv
// Shared definitions for the data-RAM arbiter: owner state encoding and the
// address window of the 32-word RAM.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } owner_t;

  localparam int RAM_WORDS = 32;

  // Address bits that may be set in a legal word access (0x7C for 32 words).
  localparam logic [31:0] ADDR_LEGAL_MASK = 32'(RAM_WORDS * 4 - 4);

endpackage

// File: rtl/dmem_arbiter_if.sv
// Per-master access port of the data-RAM arbiter: request/write bus toward the
// arbiter, grant and registered response back to the master.
interface dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid, err
  );
endinterface

// File: rtl/dmem_addr_check.sv
// Combinational legality decode: word-aligned and inside the 32-word RAM window.
module dmem_addr_check
  import dmem_pkg::*;
(
  input  logic [31:0] i_addr,
  output logic        o_legal
);
  assign o_legal = (i_addr & ~ADDR_LEGAL_MASK) == 32'd0;
endmodule

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the single-port data RAM, with a hold limit
// while the other master waits, address legality checks and registered responses.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          clrn,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  owner_t      r_owner;
  owner_t      w_owner_nxt;
  logic        r_last;
  logic [7:0]  r_hold_cnt;
  logic        r_rvalid0, r_rvalid1, r_err0, r_err1;
  logic [31:0] r_rdata0, r_rdata1;

  logic w_gnt0, w_gnt1, w_acc0, w_acc1;
  logic w_sel_we, w_own_req, w_other_req, w_legal, w_rd_ok;

  assign w_gnt0  = (r_owner == OWN0);
  assign w_gnt1  = (r_owner == OWN1);
  assign w_acc0  = w_gnt0 & m0.req;
  assign w_acc1  = w_gnt1 & m1.req;
  assign w_rd_ok = w_legal & ~w_sel_we;

  // Owner-selected bus toward the RAM; IDLE drives zeros.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    mem_addr    = '0;
    mem_wdata   = '0;
    w_sel_we    = 1'b0;
    w_own_req   = 1'b0;
    w_other_req = 1'b0;
    case (r_owner)
      OWN0: begin
        mem_addr    = m0.addr;
        mem_wdata   = m0.wdata;
        w_sel_we    = m0.we;
        w_own_req   = m0.req;
        w_other_req = m1.req;
      end
      OWN1: begin
        mem_addr    = m1.addr;
        mem_wdata   = m1.wdata;
        w_sel_we    = m1.we;
        w_own_req   = m1.req;
        w_other_req = m0.req;
      end
      default: ;
    endcase
  end

  dmem_addr_check u_addr_check (
    .i_addr  (mem_addr),
    .o_legal (w_legal)
  );

  // A write in a reset cycle must not reach the RAM.
  assign mem_we = clrn & (w_acc0 | w_acc1) & w_sel_we & w_legal;

  always_comb begin
    w_owner_nxt = r_owner;
    case (r_owner)
      IDLE: begin
        if (m0.req && m1.req) w_owner_nxt = r_last ? OWN0 : OWN1;
        else if (m0.req)      w_owner_nxt = OWN0;
        else if (m1.req)      w_owner_nxt = OWN1;
        else                  w_owner_nxt = IDLE;
      end
      OWN0, OWN1: begin
        if (w_other_req && (!w_own_req || r_hold_cnt == HOLD_LAST))
          w_owner_nxt = (r_owner == OWN0) ? OWN1 : OWN0;
        else if (w_own_req)
          w_owner_nxt = r_owner;
        else
          w_owner_nxt = IDLE;
      end
      default: w_owner_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    if (!clrn) begin
      r_owner    <= IDLE;
      r_last     <= 1'b0;
      r_hold_cnt <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      if (r_owner == OWN0 && w_owner_nxt != OWN0)      r_last <= 1'b0;
      else if (r_owner == OWN1 && w_owner_nxt != OWN1) r_last <= 1'b1;

      // Hold counter only runs while the other master is kept waiting.
      if (w_owner_nxt != r_owner || !w_other_req) r_hold_cnt <= '0;
      else if (r_hold_cnt != HOLD_LAST)           r_hold_cnt <= r_hold_cnt + 8'd1;

      r_rvalid0 <= w_acc0 & w_rd_ok;
      r_rvalid1 <= w_acc1 & w_rd_ok;
      r_err0    <= w_acc0 & ~w_legal;
      r_err1    <= w_acc1 & ~w_legal;
      if (w_acc0 & w_rd_ok) r_rdata0 <= mem_rdata;
      if (w_acc1 & w_rd_ok) r_rdata1 <= mem_rdata;
    end
  end

  assign m0.gnt    = w_gnt0;
  assign m1.gnt    = w_gnt1;
  assign m0.rvalid = r_rvalid0;
  assign m1.rvalid = r_rvalid1;
  assign m0.err    = r_err0;
  assign m1.err    = r_err1;
  assign m0.rdata  = r_rdata0;
  assign m1.rdata  = r_rdata1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a RAM model behind the DUT, a shadow copy of the
// RAM contents and per-master response queues checked every cycle.
module tb_dmem_arbiter;

  typedef struct {
    int          due;
    logic        is_err;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic clrn;
  logic tb_init;
  bit   mon_en = 1'b0;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_rv0  = 0;

  resp_t       q0[$];
  resp_t       q1[$];
  logic [31:0] shadow [32];
  logic [31:0] ram    [32];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter_if bus0 ();
  dmem_arbiter_if bus1 ();
  dmem_arbiter_if hb0 ();
  dmem_arbiter_if hb1 ();

  logic        mem_we, h_mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, h_mem_addr, h_mem_wdata;

  dmem_arbiter #(.MAX_HOLD(4)) u_dut (
    .clk       (clk),
    .clrn      (clrn),
    .m0        (bus0),
    .m1        (bus1),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  dmem_arbiter #(.MAX_HOLD(1)) u_dut_h1 (
    .clk       (clk),
    .clrn      (clrn),
    .m0        (hb0),
    .m1        (hb1),
    .mem_we    (h_mem_we),
    .mem_addr  (h_mem_addr),
    .mem_wdata (h_mem_wdata),
    .mem_rdata (32'h0)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  function automatic bit tb_legal(input logic [31:0] a);
    return (a[31:7] == 25'd0) && (a[1:0] == 2'd0);
  endfunction

  // RAM with combinational read, preloaded during the first reset cycle
  assign mem_rdata = ram[mem_addr[6:2]];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 32; i++) ram[i] <= init_word(i);
    end else if (mem_we) begin
      ram[mem_addr[6:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic note_one(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    resp_t r;
    r.due    = cyc + 1;
    r.is_err = 1'b0;
    r.data   = 32'h0;
    if (!tb_legal(addr)) begin
      r.is_err = 1'b1;
      if (k == 0) q0.push_back(r); else q1.push_back(r);
    end else if (we) begin
      shadow[addr[6:2]] = wdata;
    end else begin
      r.data = shadow[addr[6:2]];
      if (k == 0) q0.push_back(r); else q1.push_back(r);
    end
  endtask

  // Record what the coming edge accepts; a reset edge accepts nothing.
  task automatic note_accepts();
    if (clrn) begin
      if (bus0.gnt && bus0.req) note_one(0, bus0.we, bus0.addr, bus0.wdata);
      if (bus1.gnt && bus1.req) note_one(1, bus1.we, bus1.addr, bus1.wdata);
    end
  endtask

  task automatic tick();
    #1;
    note_accepts();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_master(input int k, input logic rv, input logic er, input logic [31:0] rd);
    resp_t e;
    bit    have;
    e    = '{0, 1'b0, 32'h0};
    have = 1'b0;
    if (k == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1'b1; end
    end
    check($sformatf("m%0d_rvalid@%0d", k, cyc), {31'b0, rv}, {31'b0, have && !e.is_err});
    check($sformatf("m%0d_err@%0d", k, cyc), {31'b0, er}, {31'b0, have && e.is_err});
    if (have && !e.is_err) check($sformatf("m%0d_rdata@%0d", k, cyc), rd, e.data);
    if (k == 0 && rv) n_rv0++;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_master(0, bus0.rvalid, bus0.err, bus0.rdata);
      mon_master(1, bus1.rvalid, bus1.err, bus1.rdata);
    end
  end

  task automatic do_reset();
    clrn     = 1'b0;
    bus0.req = 1'b0;
    bus1.req = 1'b0;
    hb0.req  = 1'b0;
    hb1.req  = 1'b0;
    tick();
    clrn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base;
    for (int i = 0; i < 32; i++) shadow[i] = init_word(i);
    clrn    = 1'b0;
    tb_init = 1'b1;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    hb0.req  = 1'b0; hb0.we  = 1'b0; hb0.addr  = '0; hb0.wdata  = '0;
    hb1.req  = 1'b0; hb1.we  = 1'b0; hb1.addr  = '0; hb1.wdata  = '0;
    @(posedge clk);
    #1;
    tb_init = 1'b0;
    mon_en  = 1'b1;

    // Reset state
    #1;
    check("rst_gnt0", bus0.gnt, 0);
    check("rst_gnt1", bus1.gnt, 0);
    check("rst_rvalid0", bus0.rvalid, 0);
    check("rst_err1", bus1.err, 0);
    check("rst_rdata0", bus0.rdata, 0);
    check("rst_rdata1", bus1.rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    // m0 writes 0x258 to 0x60, then reads it back
    clrn = 1'b1;
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'h60; bus0.wdata = 32'h258;
    #1;
    check("wr_gnt0_c0", bus0.gnt, 0);
    tick();
    #1;
    check("wr_gnt0_c1", bus0.gnt, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 32'h60);
    check("wr_mem_wdata", mem_wdata, 32'h258);
    tick();
    bus0.we = 1'b0;
    tick();
    bus0.req = 1'b0;
    #1;
    check("rd_gnt0_hold", bus0.gnt, 1);
    tick();
    #1;
    check("rd_gnt0_idle", bus0.gnt, 0);

    // Simultaneous requests from reset: m1 first, m0 follows with no gap
    do_reset();
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h50;
    bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 32'h54;
    tick();
    #1;
    check("rr_gnt1_first", bus1.gnt, 1);
    check("rr_gnt0_wait", bus0.gnt, 0);
    check("rr_mem_addr", mem_addr, 32'h54);
    tick();
    bus1.req = 1'b0;
    tick();
    #1;
    check("rr_gnt0_next", bus0.gnt, 1);
    check("rr_gnt1_off", bus1.gnt, 0);
    tick();
    bus0.req = 1'b0;
    tick();
    tick();

    // Hold limit of 4 while the other master waits, both directions
    do_reset();
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h58;
    tick();
    tick();
    bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 32'h5C;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("hold_gnt0_%0d", i), bus0.gnt, 1);
      tick();
    end
    #1;
    check("hold_gnt1_after", bus1.gnt, 1);
    check("hold_gnt0_after", bus0.gnt, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check($sformatf("hold_gnt1_%0d", i), bus1.gnt, 1);
    end
    tick();
    #1;
    check("hold_gnt0_back", bus0.gnt, 1);
    bus0.req = 1'b0;
    bus1.req = 1'b0;
    tick();
    tick();
    tick();

    // Illegal accesses on m1: errors, no write, no read data
    do_reset();
    bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 32'h80;
    tick();
    #1;
    check("err_mem_we_rd80", mem_we, 0);
    tick();
    bus1.addr = 32'h52;
    tick();
    bus1.we = 1'b1; bus1.addr = 32'h80; bus1.wdata = 32'hDEAD_BEEF;
    #1;
    check("err_mem_we_wr80", mem_we, 0);
    tick();
    bus1.we = 1'b0; bus1.addr = 32'h7C;
    tick();
    bus1.addr = 32'h00;
    tick();
    bus1.req = 1'b0;
    tick();
    tick();

    // Reset during an m0 read accept drops the response
    do_reset();
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h60;
    tick();
    #1;
    check("rstmid_gnt0", bus0.gnt, 1);
    clrn = 1'b0;
    tick();
    bus0.req = 1'b0;
    #1;
    check("rstmid_gnt0_off", bus0.gnt, 0);
    check("rstmid_gnt1_off", bus1.gnt, 0);
    check("rstmid_mem_addr", mem_addr, 0);
    clrn = 1'b1;
    tick();
    tick();

    // 8 back-to-back reads of 0x50..0x6C
    do_reset();
    base = n_rv0;
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'h50;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus0.addr = 32'h50 + 32'(i * 4);
      tick();
    end
    bus0.req = 1'b0;
    tick();
    tick();
    check("stream_rvalid_count", 32'(n_rv0 - base), 8);

    // MAX_HOLD = 1: ownership alternates every cycle
    do_reset();
    hb0.req = 1'b1;
    hb1.req = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("h1_gnt1_%0d", i), hb1.gnt, {31'b0, (i % 2) == 0});
      check($sformatf("h1_gnt0_%0d", i), hb0.gnt, {31'b0, (i % 2) == 1});
      tick();
    end
    check("h1_mem_we", h_mem_we, 0);
    check("h1_mem_addr", h_mem_addr, 0);
    check("h1_mem_wdata", h_mem_wdata, 0);
    hb0.req = 1'b0;
    hb1.req = 1'b0;
    tick();
    tick();

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single-port 32-word data RAM between the CPU load/store path (master 0) and a debug/DMA loader (master 1). It sits between both masters and the RAM's `we`/`addr`/`datain`/`dataout` pins. It grants one master per cycle using registered round-robin ownership with a hold limit, blocks misaligned and out-of-range accesses, and returns registered read data with a valid strobe.

## Interface
- `MAX_HOLD`, 8: maximum consecutive granted cycles for one owner while the other master is requesting; legal range 1–255.
- `clk` input 1: clock; all state changes on the rising edge.
- `clrn` input 1: synchronous, active-low reset.
- `m0_req`, `m1_req` input 1 each: access request; held until accepted.
- `m0_we`, `m1_we` input 1 each: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` input 32 each: byte address.
- `m0_wdata`, `m1_wdata` input 32 each: write data.
- `m0_gnt`, `m1_gnt` output 1 each: registered grant; at most one is high.
- `m0_rdata`, `m1_rdata` output 32 each: registered read data.
- `m0_rvalid`, `m1_rvalid` output 1 each: one-cycle pulse; `mN_rdata` is valid.
- `m0_err`, `m1_err` output 1 each: one-cycle pulse; the access was rejected.
- `mem_we` output 1: RAM write enable.
- `mem_addr` output 32: RAM byte address.
- `mem_wdata` output 32: RAM write data.
- `mem_rdata` input 32: RAM combinational read data.

## Operation
- State `owner`: IDLE, OWN0 or OWN1. `mN_gnt` = (owner == OWNN), decoded from the state register.
- Accept: an access is accepted in a cycle where `mN_req` and `mN_gnt` are both high. A master may issue back-to-back accesses while granted.
- Memory mux: when owner is OWNN, `mem_addr` = `mN_addr` and `mem_wdata` = `mN_wdata`. In IDLE, both drive 0.
- `mem_we` = accept & `mN_we` & legal.
- Legal access: `addr[31:7]` == 0 and `addr[1:0]` == 0.
  - Illegal accepted access: `mem_we` forced 0, `mN_err` pulses the next cycle, no rvalid.
- Read: on an accepted legal read, `mem_rdata` is registered into `mN_rdata`, and `mN_rvalid` pulses the next cycle. `mN_rdata` holds its value otherwise.
- Write: no response beyond completion in the accept cycle.
- Next-owner rules, evaluated each edge; the first match wins:
  - IDLE: both requesting → the master not served last (`last` pointer, reset 0 meaning master 1 wins first); otherwise the sole requester; otherwise IDLE.
  - OWNk, other master requesting and (`mk_req` low or `hold_cnt` == MAX_HOLD−1) → OWN(other).
  - OWNk, `mk_req` high → OWNk.
  - OWNk, `mk_req` low → IDLE.
- `hold_cnt` (8 bits):
  - Clears on every owner change and whenever the other master is not requesting.
  - Otherwise increments on each granted cycle.
  - Saturates at MAX_HOLD−1.
- `last` updates to k whenever ownership leaves OWNk.

## Timing
- Reset values: owner IDLE, `last` 0, `hold_cnt` 0, all `gnt`/`rvalid`/`err` 0, all `rdata` 0. Because the mem outputs decode from IDLE, `mem_we` = 0 and `mem_addr` = `mem_wdata` = 0.
- Grant latency from IDLE: 1 cycle after `req` rises.
- Handover between masters: zero dead cycles. The new owner is granted in the cycle after the old owner's last accepted access.
- Read latency: 1 cycle from accept to `rvalid`. Error latency: 1 cycle.
- Simultaneous first requests from IDLE: round-robin via `last`.
- Reset mid-access: takes priority over everything.
  - The accept cycle's write still occurs only if `clrn` was high at that edge.
  - Any pending `rvalid`/`err` is dropped.
- MAX_HOLD = 1: ownership alternates every cycle while both masters request.

## Structure
- Shared package `dmem_pkg`: owner state encoding (IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10), RAM word count (32), legal-address mask.
- One sub-module `dmem_addr_check`: combinational legality decode (addr → legal).
- FSM, counter and muxes live in the top module.

## Test plan
- Reset, then `m0` writes 0x258 to address 0x60 → `m0_gnt` at cycle 1; `mem_we` = 1, `mem_addr` = 0x60 in the accept cycle; a later read of 0x60 returns 0x258 with `rvalid` 1 cycle after accept.
- Both masters raise `req` in the same cycle from reset → `m1_gnt` first; on `m1_req` drop, `m0_gnt` follows next cycle with no gap.
- MAX_HOLD = 4, `m0` requests continuously, `m1` requests from cycle 2 → `m0` granted 4 consecutive cycles after `m1_req` rises, then `m1` granted.
- `m1` reads 0x80, then 0x52 → `m1_err` pulses after each; `mem_we` stays 0; no `m1_rvalid`.
- `clrn` low during an `m0` read accept → `m0_rvalid` never pulses; owner IDLE; all grants 0 the cycle after reset.
- Single master streams 8 back-to-back reads of 0x50..0x6C → 8 consecutive `rvalid` pulses carrying the preloaded words in order.
